// File: rtl/rf_pkg.sv
// Shared constants and helpers for the integer register file with scoreboard.
//   RF_DATA_W  default register width
//   RF_ADDR_W  default address width
//   RF_ZERO    index of the register that can be hardwired to zero
//   rf_onehot  address -> one-hot register select for the default geometry
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_ZERO   = 0;
  localparam int RF_DEPTH  = 1 << RF_ADDR_W;

  function automatic logic [RF_DEPTH-1:0] rf_onehot(input logic [RF_ADDR_W-1:0] addr);
    logic [RF_DEPTH-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits tracking in-flight producers, plus per-port hazard flags.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   iss_en, iss_addr    issuing instruction marks its destination busy
//   wb_clr, wb_addr     writeback retires the producer of wb_addr
//   flush               clears every busy bit
//   rd_addr             NRD packed read addresses
//   rd_busy             NRD per-port "operand not yet available"
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  wb_clr,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic                  flush,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD-1:0]        rd_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] iss_dec;
  logic [DEPTH-1:0] wb_dec;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] busy_q;

  generate
    if (ADDR_W == RF_ADDR_W) begin : g_pkg_dec
      assign iss_dec = rf_onehot(iss_addr);
      assign wb_dec  = rf_onehot(wb_addr);
    end else begin : g_cmp_dec
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
        assign iss_dec[gi] = (iss_addr == ADDR_W'(gi));
        assign wb_dec[gi]  = (wb_addr == ADDR_W'(gi));
      end
    end
  endgenerate

  // Priority per register: flush, then issue (a new producer outranks the
  // retiring one on the same register), then writeback clear, else hold.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (iss_en && iss_dec[r]) begin
          busy_d[r] = 1'b1;
        end else if (wb_clr && wb_dec[r]) begin
          busy_d[r] = 1'b0;
        end
      end
    end
    if (ZERO_REG) begin
      busy_d[RF_ZERO] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A writeback retiring the same register this cycle resolves the hazard;
  // the bypass in the top level supplies the value. iss_en is deliberately
  // absent here so issue only affects the following cycle.
  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_port
      logic [ADDR_W-1:0] a;
      logic              is_zero;
      assign a       = rd_addr[gi*ADDR_W +: ADDR_W];
      assign is_zero = ZERO_REG && (a == ADDR_W'(RF_ZERO));
      assign rd_busy[gi] = busy_q[a] & ~(wb_clr && (a == wb_addr)) & ~is_zero;
    end
  endgenerate

endmodule

// File: rtl/rf_sb_bank.sv
// Integer register file for the ID stage: NRD combinational read ports with
// write-first bypass, one write port from WB, and a busy-bit scoreboard that
// raises stall when an enabled operand is still being produced.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   rd_en, rd_addr               per-port read valid and packed addresses
//   rd_data, rd_busy             packed read data and per-port hazard flag
//   stall                        any enabled port reading a busy register
//   wb_en, wb_addr, wb_data      register write
//   wb_clr                       writeback retires busy[wb_addr]
//   iss_en, iss_addr             issuing instruction sets busy[iss_addr]
//   flush                        clears all busy bits
module rf_sb_bank
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  output logic                  stall,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  wb_clr,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  flush
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];
  logic [DEPTH-1:0]  wb_dec;
  logic              wr_ok;

  generate
    if (ADDR_W == RF_ADDR_W) begin : g_pkg_dec
      assign wb_dec = rf_onehot(wb_addr);
    end else begin : g_cmp_dec
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
        assign wb_dec[gi] = (wb_addr == ADDR_W'(gi));
      end
    end
  endgenerate

  // Writes to the hardwired zero register are dropped so it stays 0 in storage.
  assign wr_ok = wb_en && !(ZERO_REG && (wb_addr == ADDR_W'(RF_ZERO)));

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      rf_d[r] = (wr_ok && wb_dec[r]) ? wb_data : rf_q[r];
    end
  end

  // Flop array rather than block RAM: reads are asynchronous and reset must
  // clear every entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        rf_q[r] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // The bypass is gated by rst so a write presented during reset cannot leak
  // onto the read ports.
  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              is_zero;
      assign a       = rd_addr[gi*ADDR_W +: ADDR_W];
      assign is_zero = ZERO_REG && (a == ADDR_W'(RF_ZERO));
      assign rd_data[gi*DATA_W +: DATA_W] =
          (rst || is_zero)           ? '0      :
          (wb_en && (a == wb_addr))  ? wb_data :
                                       rf_q[a];
    end
  endgenerate

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wb_clr   (wb_clr),
    .wb_addr  (wb_addr),
    .flush    (flush),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

  assign stall = |(rd_en & rd_busy);

endmodule

// File: tb/tb_rf_sb_bank.sv
module tb_rf_sb_bank;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 3;

  logic                  clk;
  logic                  rst;
  logic [NRD-1:0]        rd_en;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  stall;
  logic                  wb_en;
  logic [ADDR_W-1:0]     wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  wb_clr;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  flush;

  int total;
  int bad;

  rf_sb_bank #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .ZERO_REG (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .stall    (stall),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_clr   (wb_clr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance one clock and settle 1ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [2:0] en);
    rd_addr = {a2, a1, a0};
    rd_en   = en;
  endtask

  task automatic set_wb(input logic en, input logic clr, input logic [4:0] a, input logic [31:0] d);
    wb_en   = en;
    wb_clr  = clr;
    wb_addr = a;
    wb_data = d;
  endtask

  task automatic issue(input logic [4:0] a);
    iss_en   = 1'b1;
    iss_addr = a;
    step();
    iss_en   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; flush = 1'b0; iss_en = 1'b0; iss_addr = '0;
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    set_rd(5'd1, 5'd2, 5'd3, 3'b111);
    step(); step();

    // Reset state
    check("rst_data0", rd_data[31:0], 32'h0);
    check("rst_data2", rd_data[95:64], 32'h0);
    check("rst_busy", {29'd0, rd_busy}, 32'h0);
    check("rst_stall", {31'd0, stall}, 32'h0);
    rst = 1'b0;
    step();

    // Build some state, then reset asynchronously mid-cycle
    set_wb(1'b1, 1'b0, 5'd1, 32'h1111_0001);
    step();
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    issue(5'd2);
    #1;
    check("pre_rst_r1", rd_data[31:0], 32'h1111_0001);
    check("pre_rst_busy_r2", {31'd0, rd_busy[1]}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_r1", rd_data[31:0], 32'h0);
    check("async_rst_stall", {31'd0, stall}, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_r1", rd_data[31:0], 32'h0);

    // r0 is hardwired: bypass and storage both ignored, never busy
    set_rd(5'd0, 5'd0, 5'd0, 3'b001);
    set_wb(1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF);
    #1;
    check("r0_bypass", rd_data[31:0], 32'h0);
    step();
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("r0_stored", rd_data[31:0], 32'h0);
    issue(5'd0);
    check("r0_iss_stall", {31'd0, stall}, 32'h0);

    // Bypass on r5
    set_rd(5'd5, 5'd0, 5'd0, 3'b001);
    set_wb(1'b1, 1'b0, 5'd5, 32'h1234_5678);
    #1;
    check("bypass_same", rd_data[31:0], 32'h1234_5678);
    step();
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("bypass_next", rd_data[31:0], 32'h1234_5678);

    // Load-use on r7; issue has no same-cycle effect on stall
    set_rd(5'd7, 5'd0, 5'd0, 3'b001);
    iss_en = 1'b1; iss_addr = 5'd7;
    #1;
    check("iss_no_comb", {31'd0, stall}, 32'h0);
    step();
    iss_en = 1'b0;
    #1;
    check("lu_n1_stall", {31'd0, stall}, 32'h1);
    step();
    check("lu_n2_stall", {31'd0, stall}, 32'h1);
    step();
    set_wb(1'b1, 1'b1, 5'd7, 32'h0000_00A5);
    #1;
    check("lu_n3_stall", {31'd0, stall}, 32'h0);
    check("lu_n3_data", rd_data[31:0], 32'h0000_00A5);
    step();
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("lu_n4_stall", {31'd0, stall}, 32'h0);
    check("lu_n4_data", rd_data[31:0], 32'h0000_00A5);

    // Issue and retire of r9 in the same cycle: issue wins
    set_rd(5'd9, 5'd0, 5'd0, 3'b001);
    set_wb(1'b0, 1'b1, 5'd9, 32'h0);
    iss_en = 1'b1; iss_addr = 5'd9;
    step();
    iss_en = 1'b0;
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("coll_stall", {31'd0, stall}, 32'h1);
    // Clear without a write
    set_wb(1'b0, 1'b1, 5'd9, 32'h0);
    #1;
    check("clr_comb_busy", {31'd0, rd_busy[0]}, 32'h0);
    step();
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("clr_only_stall", {31'd0, stall}, 32'h0);
    check("clr_only_data", rd_data[31:0], 32'h0);

    // Flush clears everything and suppresses the concurrent issue
    issue(5'd3);
    issue(5'd4);
    issue(5'd31);
    set_rd(5'd3, 5'd4, 5'd31, 3'b111);
    #1;
    check("pre_flush_busy", {29'd0, rd_busy}, 32'h7);
    flush = 1'b1;
    iss_en = 1'b1; iss_addr = 5'd6;
    step();
    flush = 1'b0;
    iss_en = 1'b0;
    #1;
    check("flush_busy_a", {29'd0, rd_busy}, 32'h0);
    set_rd(5'd6, 5'd3, 5'd31, 3'b111);
    #1;
    check("flush_busy_b", {29'd0, rd_busy}, 32'h0);
    check("flush_stall", {31'd0, stall}, 32'h0);

    // Multi-port: r2 non-busy with data, r8 busy
    set_wb(1'b1, 1'b0, 5'd2, 32'h0000_CAFE);
    step();
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    issue(5'd8);
    set_rd(5'd2, 5'd2, 5'd8, 3'b011);
    #1;
    check("mp_stall_011", {31'd0, stall}, 32'h0);
    check("mp_busy_011", {29'd0, rd_busy}, 32'h4);
    check("mp_data_p0", rd_data[31:0], 32'h0000_CAFE);
    check("mp_data_p1", rd_data[63:32], 32'h0000_CAFE);
    rd_en = 3'b111;
    #1;
    check("mp_stall_111", {31'd0, stall}, 32'h1);
    check("mp_busy_111", {29'd0, rd_busy}, 32'h4);

    // Write to busy r8 without clear: data updates, busy stays
    set_wb(1'b1, 1'b0, 5'd8, 32'h0000_0088);
    step();
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("wr_busy_data", rd_data[95:64], 32'h0000_0088);
    check("wr_busy_keep", {31'd0, rd_busy[2]}, 32'h1);

    // Reset held with a write presented: reads still 0
    rst = 1'b1;
    set_wb(1'b1, 1'b0, 5'd8, 32'h5555_5555);
    #1;
    check("rst_hold_data", rd_data[95:64], 32'h0);
    check("rst_hold_stall", {31'd0, stall}, 32'h0);
    step();
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    step();
    check("rst_after_r8", rd_data[95:64], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
